// File: rtl/vlsu_obi_initiator.sv
// Vector load/store initiator: one VLEN-bit command becomes in-order 32-bit OBI transactions, loads reassembled.
// Latency: first req the cycle after accept; result the cycle after the last rvalid; req never withdrawn once raised.
module vlsu_obi_initiator #(
    parameter int VLEN            = 256,
    parameter int X_ID_WIDTH      = 4,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic                  cmd_we_i,
    input  logic [31:0]           cmd_addr_i,
    input  logic [VLEN-1:0]       cmd_wdata_i,
    input  logic [VLEN/8-1:0]     cmd_be_i,
    input  logic [X_ID_WIDTH-1:0] cmd_id_i,
    output logic                  res_valid_o,
    input  logic                  res_ready_i,
    output logic [VLEN-1:0]       res_rdata_o,
    output logic [X_ID_WIDTH-1:0] res_id_o,
    output logic                  res_err_o,
    output logic                  data_req_o,
    input  logic                  data_gnt_i,
    output logic [31:0]           data_addr_o,
    output logic                  data_we_o,
    output logic [3:0]            data_be_o,
    output logic [31:0]           data_wdata_o,
    input  logic                  data_rvalid_i,
    input  logic [31:0]           data_rdata_i,
    input  logic                  data_err_i
);
    localparam int NW = VLEN / 32;
    localparam int TW = (NW > 1) ? $clog2(NW) : 1;
    localparam int IW = TW + 1;
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam logic [IW-1:0] IDX_NONE  = IW'(NW);
    localparam logic [OW-1:0] OUTST_MAX = OW'(MAX_OUTSTANDING);
    localparam logic [OW-1:0] OUTST_ONE = OW'(1);
    localparam logic [PW-1:0] PTR_LAST  = PW'(MAX_OUTSTANDING - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, RESP} state_t;

    state_t                  state_q;
    logic                    we_q;
    logic [31:0]             addr_q;
    logic [VLEN-1:0]         wdata_q;
    logic [VLEN/8-1:0]       be_q;
    logic [X_ID_WIDTH-1:0]   id_q;
    logic [VLEN-1:0]         rdata_q;
    logic                    err_q;
    logic [IW-1:0]           idx_q;
    logic [OW-1:0]           outst_q;
    logic [PW-1:0]           wp_q;
    logic [PW-1:0]           rp_q;
    logic [TW-1:0]           tags_q [MAX_OUTSTANDING];

    // Lowest word index >= from whose byte-enable slice is nonzero, IDX_NONE if none remain.
    function automatic logic [IW-1:0] first_enabled(input logic [VLEN/8-1:0] be, input logic [IW-1:0] from);
        logic [IW-1:0] r;
        r = IDX_NONE;
        for (int k = NW - 1; k >= 0; k--) begin
            if (IW'(k) >= from && be[4*k +: 4] != 4'h0) r = IW'(k);
        end
        return r;
    endfunction

    logic [TW-1:0] word_sel;
    logic          issue_ok;
    logic          req_fire;
    logic          rsp_fire;
    logic [IW-1:0] next_idx;
    logic [31:0]   word_addr;

    assign word_sel  = idx_q[TW-1:0];
    assign issue_ok  = (state_q == ISSUE) && (outst_q < OUTST_MAX) && (idx_q != IDX_NONE);
    assign req_fire  = issue_ok && data_gnt_i;
    assign rsp_fire  = data_rvalid_i && (outst_q != '0);
    assign next_idx  = first_enabled(be_q, idx_q + 1'b1);
    assign word_addr = (addr_q & 32'hFFFF_FFFC) + {{(30-IW){1'b0}}, idx_q, 2'b00};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            id_q    <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            idx_q   <= IDX_NONE;
            outst_q <= '0;
            wp_q    <= '0;
            rp_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cmd_valid_i) begin
                        we_q    <= cmd_we_i;
                        addr_q  <= cmd_addr_i;
                        wdata_q <= cmd_wdata_i;
                        be_q    <= cmd_be_i;
                        id_q    <= cmd_id_i;
                        rdata_q <= '0;
                        err_q   <= 1'b0;
                        idx_q   <= first_enabled(cmd_be_i, '0);
                        state_q <= (cmd_be_i == '0) ? RESP : ISSUE;
                    end
                end
                ISSUE: begin
                    if (req_fire) begin
                        idx_q <= next_idx;
                        if (next_idx == IDX_NONE) state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (rsp_fire && outst_q == OUTST_ONE) state_q <= RESP;
                end
                RESP: begin
                    if (res_ready_i) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase

            // In-order tag FIFO: the word index travels with each granted transaction.
            if (req_fire) begin
                tags_q[wp_q] <= word_sel;
                wp_q         <= (wp_q == PTR_LAST) ? '0 : wp_q + 1'b1;
            end
            if (rsp_fire) begin
                rp_q  <= (rp_q == PTR_LAST) ? '0 : rp_q + 1'b1;
                err_q <= err_q | data_err_i;
                if (!we_q) rdata_q[32*tags_q[rp_q] +: 32] <= data_rdata_i;
            end
            if (req_fire && !rsp_fire)      outst_q <= outst_q + 1'b1;
            else if (!req_fire && rsp_fire) outst_q <= outst_q - 1'b1;
        end
    end

    assign cmd_ready_o  = (state_q == IDLE) && !rst_i;
    assign data_req_o   = issue_ok && !rst_i;
    assign data_addr_o  = rst_i ? '0 : word_addr;
    assign data_we_o    = we_q && !rst_i;
    assign data_be_o    = rst_i ? '0 : be_q[4*word_sel +: 4];
    assign data_wdata_o = (rst_i || !we_q) ? '0 : wdata_q[32*word_sel +: 32];
    assign res_valid_o  = (state_q == RESP) && !rst_i;
    assign res_rdata_o  = rst_i ? '0 : rdata_q;
    assign res_id_o     = rst_i ? '0 : id_q;
    assign res_err_o    = err_q && !rst_i;

    // A response with nothing outstanding is dropped by the logic above; flag it in simulation.
    assert property (@(posedge clk_i) disable iff (rst_i) !(data_rvalid_i && outst_q == '0));

endmodule

// File: tb/tb_vlsu_obi_initiator.sv
// Bench for vlsu_obi_initiator: randomized OBI responder plus a word-level model of each command.
module tb_vlsu_obi_initiator;
    localparam int VLEN = 256;
    localparam int NW   = VLEN / 32;
    localparam int BW   = VLEN / 8;
    localparam int XW   = 4;
    localparam int MAXO = 2;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } txn_t;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [31:0] due;
    } pend_t;

    logic clk = 1'b0;
    logic rst;
    logic cmd_valid, cmd_ready, cmd_we;
    logic [31:0] cmd_addr;
    logic [VLEN-1:0] cmd_wdata;
    logic [BW-1:0] cmd_be;
    logic [XW-1:0] cmd_id;
    logic res_valid, res_ready, res_err;
    logic [VLEN-1:0] res_rdata;
    logic [XW-1:0] res_id;
    logic data_req, data_gnt, data_we, data_rvalid, data_err;
    logic [31:0] data_addr, data_wdata, data_rdata;
    logic [3:0] data_be;

    vlsu_obi_initiator #(.VLEN(VLEN), .X_ID_WIDTH(XW), .MAX_OUTSTANDING(MAXO)) dut (
        .clk_i(clk), .rst_i(rst),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_we_i(cmd_we),
        .cmd_addr_i(cmd_addr), .cmd_wdata_i(cmd_wdata), .cmd_be_i(cmd_be), .cmd_id_i(cmd_id),
        .res_valid_o(res_valid), .res_ready_i(res_ready), .res_rdata_o(res_rdata),
        .res_id_o(res_id), .res_err_o(res_err),
        .data_req_o(data_req), .data_gnt_i(data_gnt), .data_addr_o(data_addr),
        .data_we_o(data_we), .data_be_o(data_be), .data_wdata_o(data_wdata),
        .data_rvalid_i(data_rvalid), .data_rdata_i(data_rdata), .data_err_i(data_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_fail = 0;

    // responder state and observations
    logic        stall_en = 1'b0;
    logic        err_en = 1'b0;
    logic [31:0] err_addr = 32'h0;
    txn_t        log_q[$];
    int          gcyc_q[$];
    pend_t       pend_q[$];
    int          rv_last = 0;
    int          stall_viol = 0;
    int          max_outst = 0;
    int          stall_left = 0;
    int          last_due = 0;
    int          due;
    logic        prev_hold = 1'b0;
    txn_t        prev_txn, cur;
    pend_t       p;

    // per-command model expectations and observed result
    txn_t            exp_q[$];
    logic [VLEN-1:0] exp_rd;
    logic            exp_err;
    int              acc_cyc, res_cyc;
    logic            res_seen;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h1000_0000 + (a >> 2);
    endfunction

    initial begin
        data_gnt = 1'b0; data_rvalid = 1'b0; data_rdata = '0; data_err = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                pend_q.delete();
                data_gnt = 1'b0; data_rvalid = 1'b0; data_err = 1'b0; prev_hold = 1'b0;
            end else begin
                cur = '{addr: data_addr, we: data_we, be: data_be, wdata: data_wdata};
                if (prev_hold && (!data_req || cur !== prev_txn)) stall_viol++;
                data_rvalid = 1'b0; data_err = 1'b0; data_rdata = $urandom();
                if (pend_q.size() > 0 && int'(pend_q[0].due) <= cyc) begin
                    p = pend_q.pop_front();
                    data_rvalid = 1'b1;
                    rv_last = cyc;
                    data_rdata = p.we ? $urandom() : mem_word(p.addr);
                    data_err = err_en && (p.addr == err_addr);
                end
                data_gnt = 1'b0;
                if (data_req) begin
                    if (stall_en && stall_left > 0) stall_left--;
                    else begin
                        data_gnt = 1'b1;
                        stall_left = stall_en ? int'($urandom_range(0, 3)) : 0;
                    end
                end
                if (data_req && data_gnt) begin
                    log_q.push_back(cur);
                    gcyc_q.push_back(cyc);
                    due = cyc + (stall_en ? int'($urandom_range(1, 3)) : 1);
                    if (due <= last_due) due = last_due + 1;
                    last_due = due;
                    pend_q.push_back('{addr: cur.addr, we: cur.we, due: 32'(due)});
                end
                if (pend_q.size() > max_outst) max_outst = pend_q.size();
                prev_hold = data_req && !data_gnt;
                prev_txn = cur;
            end
        end
    end

    // Word-level model: which words go on the bus, what the result holds, whether it errors.
    task automatic model_cmd(input logic we, input logic [31:0] addr, input logic [BW-1:0] be,
                             input logic [VLEN-1:0] wd);
        logic [31:0] a;
        logic [3:0]  b;
        exp_q.delete();
        exp_rd = '0;
        exp_err = 1'b0;
        for (int k = 0; k < NW; k++) begin
            a = (addr & 32'hFFFF_FFFC) + 32'(4 * k);
            b = be[4*k +: 4];
            if (b != 4'h0) begin
                exp_q.push_back('{addr: a, we: we, be: b, wdata: we ? wd[32*k +: 32] : 32'h0});
                if (!we) exp_rd[32*k +: 32] = mem_word(a);
                if (err_en && a == err_addr) exp_err = 1'b1;
            end
        end
    endtask

    task automatic start_cmd(input logic we, input logic [31:0] addr, input logic [BW-1:0] be,
                             input logic [VLEN-1:0] wd, input logic [XW-1:0] id);
        int n;
        n = 0;
        while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
        log_q.delete();
        gcyc_q.delete();
        cmd_valid = 1'b1; cmd_we = we; cmd_addr = addr; cmd_be = be; cmd_wdata = wd; cmd_id = id;
        acc_cyc = cyc;
        model_cmd(we, addr, be, wd);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    // Runs a command up to its first res_valid cycle; the result is left unconsumed.
    task automatic run_cmd(input logic we, input logic [31:0] addr, input logic [BW-1:0] be,
                           input logic [VLEN-1:0] wd, input logic [XW-1:0] id);
        int n;
        start_cmd(we, addr, be, wd, id);
        n = 0;
        while (!res_valid && n < 500) begin @(negedge clk); n++; end
        res_seen = res_valid;
        res_cyc = cyc;
    endtask

    task automatic pop_res();
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++; if ({cmd_ready, res_valid, data_req, res_err, data_we} !== 5'b0) begin n_fail++; $display("FAIL reset_ctrl: got %b want 00000", {cmd_ready, res_valid, data_req, res_err, data_we}); end
        n_cmp++; if ({res_rdata, res_id, data_addr, data_be, data_wdata} !== '0) begin n_fail++; $display("FAIL reset_data: got nonzero id=%h addr=%h", res_id, data_addr); end
        rst = 1'b0;
        @(negedge clk);
        n_cmp++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", cmd_ready); end
        n_cmp++; if ({res_valid, data_req} !== 2'b0) begin n_fail++; $display("FAIL reset_idle: got %b want 00", {res_valid, data_req}); end
    endtask

    task automatic test_load_basic();
        run_cmd(1'b0, 32'h100, {BW{1'b1}}, '0, 4'h5);
        n_cmp++; if (log_q.size() != exp_q.size()) begin n_fail++; $display("FAIL load_count: got %0d want %0d", log_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
            n_cmp++; if (log_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL load_txn%0d: got %h want %h", i, log_q[i], exp_q[i]); end
        end
        n_cmp++; if (log_q.size() > 7 && log_q[7].addr !== 32'h11C) begin n_fail++; $display("FAIL load_last_addr: got %h want 0000011c", log_q[7].addr); end
        n_cmp++; if (gcyc_q.size() != 8 || gcyc_q[0] != acc_cyc + 1 || gcyc_q[7] != acc_cyc + 8) begin n_fail++; $display("FAIL load_req_cycles: got %0d grants, first %0d want 8 grants cycles 1..8", gcyc_q.size(), gcyc_q.size() > 0 ? gcyc_q[0] - acc_cyc : -1); end
        n_cmp++; if (!res_seen || res_cyc != acc_cyc + 10) begin n_fail++; $display("FAIL load_latency: got cycle %0d (seen %b) want 10", res_cyc - acc_cyc, res_seen); end
        n_cmp++; if (res_rdata !== exp_rd) begin n_fail++; $display("FAIL load_rdata: got %h want %h", res_rdata, exp_rd); end
        n_cmp++; if (res_rdata[31:0] !== 32'h1000_0040 || res_rdata[255:224] !== 32'h1000_0047) begin n_fail++; $display("FAIL load_rdata_ends: got %h %h want 10000040 10000047", res_rdata[31:0], res_rdata[255:224]); end
        n_cmp++; if ({res_id, res_err} !== {4'h5, 1'b0}) begin n_fail++; $display("FAIL load_id_err: got %h/%b want 5/0", res_id, res_err); end
        pop_res();
    endtask

    task automatic test_store_sparse();
        logic [VLEN-1:0] wd;
        for (int k = 0; k < NW; k++) wd[32*k +: 32] = 32'hA5A5_0000 + 32'(k);
        run_cmd(1'b1, 32'h400, 32'h0F0F_0F0F, wd, 4'hA);
        n_cmp++; if (log_q.size() != exp_q.size()) begin n_fail++; $display("FAIL store_count: got %0d want %0d", log_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
            n_cmp++; if (log_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL store_txn%0d: got %h want %h", i, log_q[i], exp_q[i]); end
        end
        n_cmp++; if (!res_seen || res_rdata !== '0 || res_id !== 4'hA || res_err !== 1'b0) begin n_fail++; $display("FAIL store_result: seen %b id %h err %b rdata_lo %h want 1 a 0 0", res_seen, res_id, res_err, res_rdata[31:0]); end
        pop_res();
        run_cmd(1'b1, 32'h800, 32'h0000_FF0F, wd, 4'hB);
        n_cmp++; if (log_q.size() != 3 || log_q.size() != exp_q.size()) begin n_fail++; $display("FAIL store2_count: got %0d want 3", log_q.size()); end
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
            n_cmp++; if (log_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL store2_txn%0d: got %h want %h", i, log_q[i], exp_q[i]); end
        end
        n_cmp++; if (!res_seen || res_cyc != rv_last + 1) begin n_fail++; $display("FAIL store2_resp_cycle: got %0d want %0d", res_cyc, rv_last + 1); end
        pop_res();
    endtask

    task automatic test_zero_be();
        run_cmd(1'b0, 32'h200, '0, '0, 4'h3);
        n_cmp++; if (log_q.size() != 0) begin n_fail++; $display("FAIL zero_be_txns: got %0d want 0", log_q.size()); end
        n_cmp++; if (!res_seen || res_cyc != acc_cyc + 1) begin n_fail++; $display("FAIL zero_be_latency: got %0d want 1", res_cyc - acc_cyc); end
        n_cmp++; if (res_rdata !== '0 || res_id !== 4'h3) begin n_fail++; $display("FAIL zero_be_result: got id %h rdata_lo %h want 3 0", res_id, res_rdata[31:0]); end
        pop_res();
    endtask

    task automatic test_wrap();
        run_cmd(1'b0, 32'hFFFF_FFF0, {BW{1'b1}}, '0, 4'h7);
        n_cmp++; if (log_q.size() != exp_q.size()) begin n_fail++; $display("FAIL wrap_count: got %0d want %0d", log_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
            n_cmp++; if (log_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL wrap_txn%0d: got %h want %h", i, log_q[i], exp_q[i]); end
        end
        n_cmp++; if (log_q.size() > 4 && (log_q[3].addr !== 32'hFFFF_FFFC || log_q[4].addr !== 32'h0)) begin n_fail++; $display("FAIL wrap_addr: got %h %h want fffffffc 00000000", log_q[3].addr, log_q[4].addr); end
        n_cmp++; if (!res_seen || res_rdata !== exp_rd) begin n_fail++; $display("FAIL wrap_rdata: got %h want %h", res_rdata, exp_rd); end
        pop_res();
    endtask

    task automatic test_error();
        err_en = 1'b1;
        err_addr = 32'h200 + 32'd20;
        run_cmd(1'b0, 32'h200, {BW{1'b1}}, '0, 4'h9);
        n_cmp++; if (log_q.size() != 8) begin n_fail++; $display("FAIL err_count: got %0d want 8", log_q.size()); end
        n_cmp++; if (!res_seen || res_err !== 1'b1 || exp_err !== 1'b1) begin n_fail++; $display("FAIL err_flag: got %b want 1", res_err); end
        n_cmp++; if (res_rdata !== exp_rd) begin n_fail++; $display("FAIL err_rdata: got %h want %h", res_rdata, exp_rd); end
        pop_res();
        run_cmd(1'b0, 32'h300, {BW{1'b1}}, '0, 4'hC);
        n_cmp++; if (!res_seen || res_err !== 1'b0) begin n_fail++; $display("FAIL err_cleared: got %b want 0", res_err); end
        pop_res();
        err_en = 1'b0;
    endtask

    task automatic test_res_hold();
        logic [VLEN-1:0] rd0;
        logic [XW-1:0]   id0;
        logic            er0;
        run_cmd(1'b0, 32'h1000, 32'hFFFF_00FF, '0, 4'hE);
        rd0 = res_rdata; id0 = res_id; er0 = res_err;
        n_cmp++; if (!res_seen || rd0 !== exp_rd) begin n_fail++; $display("FAIL hold_rdata: got %h want %h", rd0, exp_rd); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_cmp++; if ({res_valid, cmd_ready, res_rdata, res_id, res_err} !== {1'b1, 1'b0, exp_rd, 4'hE, 1'b0}) begin n_fail++; $display("FAIL hold_stable%0d: got valid %b ready %b id %h want 1 0 e", i, res_valid, cmd_ready, res_id); end
        end
        pop_res();
        n_cmp++; if ({res_valid, cmd_ready} !== 2'b01) begin n_fail++; $display("FAIL hold_release: got %b want 01", {res_valid, cmd_ready}); end
    endtask

    task automatic test_random_stalls();
        logic [VLEN-1:0] wd;
        logic [BW-1:0]   be;
        logic [XW-1:0]   id;
        logic            we;
        stall_en = 1'b1;
        stall_viol = 0;
        max_outst = 0;
        for (int c = 0; c < 8; c++) begin
            for (int k = 0; k < NW; k++) wd[32*k +: 32] = $urandom();
            be = $urandom();
            if (c % 2 == 1) be = be & $urandom();
            we = 1'($urandom_range(0, 1));
            id = 4'($urandom_range(0, 15));
            run_cmd(we, $urandom(), be, wd, id);
            n_cmp++; if (log_q.size() != exp_q.size()) begin n_fail++; $display("FAIL rand%0d_count: got %0d want %0d", c, log_q.size(), exp_q.size()); end
            for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
                n_cmp++; if (log_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rand%0d_txn%0d: got %h want %h", c, i, log_q[i], exp_q[i]); end
            end
            n_cmp++; if (!res_seen || {res_rdata, res_id, res_err} !== {exp_rd, id, 1'b0}) begin n_fail++; $display("FAIL rand%0d_result: got id %h err %b rdata %h want id %h rdata %h", c, res_id, res_err, res_rdata, id, exp_rd); end
            pop_res();
        end
        n_cmp++; if (stall_viol != 0) begin n_fail++; $display("FAIL rand_req_stable: got %0d changes want 0", stall_viol); end
        n_cmp++; if (max_outst > MAXO) begin n_fail++; $display("FAIL rand_outstanding: got %0d want <= %0d", max_outst, MAXO); end
        stall_en = 1'b0;
    endtask

    task automatic test_reset_mid();
        int n;
        start_cmd(1'b0, 32'h2000, {BW{1'b1}}, '0, 4'h6);
        n = 0;
        while (log_q.size() < 3 && n < 50) begin @(negedge clk); n++; end
        n_cmp++; if (data_req !== 1'b1) begin n_fail++; $display("FAIL mid_in_issue: got req %b want 1", data_req); end
        rst = 1'b1;
        @(negedge clk);
        n_cmp++; if ({cmd_ready, res_valid, data_req, data_we, res_err, res_rdata, res_id, data_addr, data_be, data_wdata} !== '0) begin n_fail++; $display("FAIL mid_reset_outputs: got req %b addr %h be %h want all 0", data_req, data_addr, data_be); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_cmd(1'b0, 32'h3000, {BW{1'b1}}, '0, 4'h2);
        n_cmp++; if (log_q.size() != exp_q.size()) begin n_fail++; $display("FAIL mid_fresh_count: got %0d want %0d", log_q.size(), exp_q.size()); end
        n_cmp++; if (!res_seen || {res_rdata, res_id, res_err} !== {exp_rd, 4'h2, 1'b0}) begin n_fail++; $display("FAIL mid_fresh_result: got id %h rdata %h want 2 %h", res_id, res_rdata, exp_rd); end
        pop_res();
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        cmd_be = '0; cmd_id = '0; res_ready = 1'b0;
        test_reset();
        test_load_basic();
        test_store_sparse();
        test_zero_be();
        test_wrap();
        test_error();
        test_res_hold();
        test_random_stalls();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
